// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU load/store, coprocessor burst-DMA and memory-side signals
// around the data-memory write port arbiter.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4,
    parameter int LEN_WIDTH      = 6
);
    logic                      cpu_req_i;
    logic                      cpu_we_i;
    logic [ADDR_WIDTH-1:0]     cpu_addr_i;
    logic [DATA_WIDTH-1:0]     cpu_wdata_i;
    logic [TRANSFER_WIDTH-1:0] cpu_be_i;
    logic                      cpu_gnt_o;
    logic                      cpu_rvalid_o;
    logic [DATA_WIDTH-1:0]     cpu_rdata_o;

    logic                      cop_req_i;
    logic                      cop_we_i;
    logic [ADDR_WIDTH-1:0]     cop_addr_i;
    logic [LEN_WIDTH-1:0]      cop_len_i;
    logic                      cop_ready_i;
    logic [DATA_WIDTH-1:0]     cop_wdata_i;
    logic                      cop_ack_o;
    logic                      cop_beat_o;
    logic                      cop_rvalid_o;
    logic [DATA_WIDTH-1:0]     cop_rdata_o;
    logic                      cop_done_o;

    logic                      mem_we_o;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic [TRANSFER_WIDTH-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  cop_req_i, cop_we_i, cop_addr_i, cop_len_i, cop_ready_i, cop_wdata_i,
        output cop_ack_o, cop_beat_o, cop_rvalid_o, cop_rdata_o, cop_done_o,
        output mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    // Requester / memory side.
    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output cop_req_i, cop_we_i, cop_addr_i, cop_len_i, cop_ready_i, cop_wdata_i,
        input  cop_ack_o, cop_beat_o, cop_rvalid_o, cop_rdata_o, cop_done_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory's write-capable port between single-word CPU accesses
// and coprocessor linear bursts, with periodic CPU slots inside long bursts.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4,
    parameter int LEN_WIDTH      = 6,
    parameter int COP_SLICE      = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    dmem_port_arbiter_if.slave  bus
);
    localparam int SLICE_WIDTH = $clog2(COP_SLICE + 1);

    typedef enum logic [1:0] {IDLE, BURST, CPU_SLOT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   prio_cop_q, prio_cop_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic                   we_q, we_d;
    logic [SLICE_WIDTH-1:0] slice_q, slice_d;

    logic                   cpu_gnt;
    logic                   cop_beat;
    logic                   cpu_rvalid_q, cop_rvalid_q;
    logic [DATA_WIDTH-1:0]  cpu_rdata_q, cop_rdata_q;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_cop_q <= 1'b1;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            slice_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_cop_q <= prio_cop_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            slice_q    <= slice_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches.
        state_d         = state_q;
        prio_cop_d      = prio_cop_q;
        base_d          = base_q;
        len_d           = len_q;
        idx_d           = idx_q;
        we_d            = we_q;
        slice_d         = slice_q;
        cpu_gnt         = 1'b0;
        cop_beat        = 1'b0;
        bus.cop_ack_o   = 1'b0;
        bus.cop_done_o  = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_be_o    = '0;

        // While reset is held no access may reach the memory.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cpu_req_i && !(bus.cop_req_i && prio_cop_q)) begin
                        cpu_gnt = 1'b1;
                    end else if (bus.cop_req_i) begin
                        bus.cop_ack_o = 1'b1;
                        base_d        = {bus.cop_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        len_d         = bus.cop_len_i;
                        we_d          = bus.cop_we_i;
                        idx_d         = '0;
                        slice_d       = '0;
                        prio_cop_d    = 1'b0;
                        state_d       = (bus.cop_len_i == '0) ? DONE : BURST;
                    end
                end
                BURST: begin
                    if (bus.cop_ready_i) begin
                        cop_beat        = 1'b1;
                        bus.mem_we_o    = we_q;
                        bus.mem_addr_o  = base_q + ADDR_WIDTH'({idx_q, 2'b00});
                        bus.mem_wdata_o = bus.cop_wdata_i;
                        bus.mem_be_o    = '1;
                        idx_d           = idx_q + 1'b1;
                        if (slice_q != SLICE_WIDTH'(COP_SLICE)) slice_d = slice_q + 1'b1;
                    end
                    // The slice counter saturates, so a late CPU request still gets the next slot.
                    if (cop_beat && idx_d == len_q) begin
                        state_d = DONE;
                    end else if (slice_d == SLICE_WIDTH'(COP_SLICE) && bus.cpu_req_i) begin
                        state_d = CPU_SLOT;
                        slice_d = '0;
                    end
                end
                CPU_SLOT: begin
                    cpu_gnt = bus.cpu_req_i;
                    state_d = BURST;
                end
                DONE: begin
                    bus.cop_done_o = 1'b1;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (cpu_gnt) begin
                bus.mem_we_o    = bus.cpu_we_i;
                bus.mem_addr_o  = bus.cpu_addr_i;
                bus.mem_wdata_o = bus.cpu_wdata_i;
                bus.mem_be_o    = bus.cpu_be_i;
                prio_cop_d      = 1'b1;
            end
        end
    end

    // Read data is captured from the combinational memory the cycle it is addressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            cop_rvalid_q <= 1'b0;
            cop_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt && !bus.cpu_we_i;
            cop_rvalid_q <= cop_beat && !we_q;
            if (cpu_gnt && !bus.cpu_we_i) cpu_rdata_q <= bus.mem_rdata_i;
            if (cop_beat && !we_q) cop_rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.cpu_gnt_o    = cpu_gnt;
    assign bus.cop_beat_o   = cop_beat;
    assign bus.cpu_rvalid_o = cpu_rvalid_q;
    assign bus.cpu_rdata_o  = cpu_rdata_q;
    assign bus.cop_rvalid_o = cop_rvalid_q;
    assign bus.cop_rdata_o  = cop_rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model with its own memory.
module tb_dmem_port_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int LW    = 6;
    localparam int SLICE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(TW), .LEN_WIDTH(LW)) bus ();

    dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(TW), .LEN_WIDTH(LW), .COP_SLICE(SLICE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory seen by the DUT, and the model's private copy.
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] ref_mem [256];
    assign bus.mem_rdata_i = env_mem[bus.mem_addr_o[AW-1:2]];

    always @(posedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            for (int b = 0; b < TW; b++)
                if (bus.mem_be_o[b]) env_mem[bus.mem_addr_o[AW-1:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_prio, m_active, m_slot, m_done, m_we;
    int            m_base, m_len, m_beats, m_since;
    bit            m_cpu_rvalid, m_cop_rvalid;
    logic [DW-1:0] m_cpu_rdata, m_cop_rdata;
    bit            m_gnt_last, m_ack_last;

    bit            e_gnt, e_ack, e_beat, e_done, e_we;
    int            e_addr;
    logic [DW-1:0] e_wdata;
    logic [TW-1:0] e_be;

    // What the port must do this cycle, given the model's burst record and the inputs.
    task automatic model_eval();
        e_gnt = 0; e_ack = 0; e_beat = 0; e_done = 0; e_we = 0;
        e_addr = 0; e_wdata = '0; e_be = '0;
        if (rst_n !== 1'b1) return;
        if (m_done) e_done = 1;
        else if (m_slot) e_gnt = bus.cpu_req_i;
        else if (m_active) begin
            if (bus.cop_ready_i) begin
                e_beat  = 1;
                e_addr  = (m_base + 4 * m_beats) % (1 << AW);
                e_we    = m_we;
                e_be    = '1;
                e_wdata = bus.cop_wdata_i;
            end
        end else if (bus.cpu_req_i && !(bus.cop_req_i && m_prio)) e_gnt = 1;
        else if (bus.cop_req_i) e_ack = 1;
        if (e_gnt) begin
            e_addr  = int'(bus.cpu_addr_i);
            e_we    = bus.cpu_we_i;
            e_be    = bus.cpu_be_i;
            e_wdata = bus.cpu_wdata_i;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_prio = 1; m_active = 0; m_slot = 0; m_done = 0; m_we = 0;
            m_base = 0; m_len = 0; m_beats = 0; m_since = 0;
            m_cpu_rvalid = 0; m_cop_rvalid = 0; m_cpu_rdata = '0; m_cop_rdata = '0;
            m_gnt_last = 0; m_ack_last = 0;
        end else begin
            model_eval();
            m_gnt_last   = e_gnt;
            m_ack_last   = e_ack;
            m_cpu_rvalid = e_gnt && !e_we;
            m_cop_rvalid = e_beat && !e_we;
            if (m_cpu_rvalid) m_cpu_rdata = ref_mem[e_addr / 4];
            if (m_cop_rvalid) m_cop_rdata = ref_mem[e_addr / 4];
            if ((e_gnt || e_beat) && e_we)
                for (int b = 0; b < TW; b++)
                    if (e_be[b]) ref_mem[e_addr / 4][8*b +: 8] = e_wdata[8*b +: 8];
            if (e_gnt) m_prio = 1;
            if (m_done) m_done = 0;
            else if (m_slot) m_slot = 0;
            else if (m_active) begin
                if (e_beat) begin
                    m_beats++;
                    m_since++;
                end
                if (e_beat && m_beats == m_len) begin
                    m_active = 0;
                    m_done   = 1;
                end else if (m_since >= SLICE && bus.cpu_req_i) begin
                    m_slot  = 1;
                    m_since = 0;
                end
            end else if (e_ack) begin
                m_base  = (int'(bus.cop_addr_i) / 4) * 4;
                m_len   = int'(bus.cop_len_i);
                m_we    = bus.cop_we_i;
                m_beats = 0;
                m_since = 0;
                m_prio  = 0;
                if (m_len == 0) m_done = 1;
                else m_active = 1;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            model_eval();
            check("cpu_gnt",    32'(bus.cpu_gnt_o),    32'(e_gnt));
            check("cop_ack",    32'(bus.cop_ack_o),    32'(e_ack));
            check("cop_beat",   32'(bus.cop_beat_o),   32'(e_beat));
            check("cop_done",   32'(bus.cop_done_o),   32'(e_done));
            check("mem_we",     32'(bus.mem_we_o),     32'(e_we));
            check("mem_be",     32'(bus.mem_be_o),     32'(e_be));
            check("mem_addr",   32'(bus.mem_addr_o),   32'(e_addr));
            check("mem_wdata",  bus.mem_wdata_o,       e_wdata);
            check("cpu_rvalid", 32'(bus.cpu_rvalid_o), 32'(m_cpu_rvalid));
            check("cop_rvalid", 32'(bus.cop_rvalid_o), 32'(m_cop_rvalid));
            if (m_cpu_rvalid) check("cpu_rdata", bus.cpu_rdata_o, m_cpu_rdata);
            if (m_cop_rvalid) check("cop_rdata", bus.cop_rdata_o, m_cop_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0; bus.cpu_be_i = '0;
        bus.cop_req_i = 0; bus.cop_we_i = 0; bus.cop_addr_i = '0; bus.cop_len_i = '0;
        bus.cop_ready_i = 0; bus.cop_wdata_i = '0;
    endtask

    task automatic settle();
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic cop_start(input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bus.cop_req_i = 1; bus.cop_we_i = we; bus.cop_addr_i = addr; bus.cop_len_i = len;
        bus.cop_ready_i = 1; bus.cop_wdata_i = $urandom;
    endtask

    int          done_cyc;
    int          beats;
    int          a10;
    int          gnt_q[$];
    logic [31:0] addr_q[$];
    int          exp_wrap[4] = '{32'h3F8, 32'h3FC, 32'h000, 32'h004};

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        env_mem[1] = 32'hAABBCCDD; ref_mem[1] = 32'hAABBCCDD;
        idle_inputs();
        rst_n = 0;
        tick();
        checking = 1;
        #2;
        check("reset_cpu_rdata", bus.cpu_rdata_o, 32'h0);
        check("reset_mem_be",    32'(bus.mem_be_o), 32'h0);
        tick();
        rst_n = 1;

        // CPU read of 0x010.
        bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 10'h010;
        #2;
        check("rd_gnt", 32'(bus.cpu_gnt_o), 32'h1);
        check("rd_mem_we", 32'(bus.mem_we_o), 32'h0);
        tick();
        bus.cpu_req_i = 0;
        #2;
        check("rd_rvalid", 32'(bus.cpu_rvalid_o), 32'h1);
        check("rd_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);

        // CPU partial write, then readback.
        tick();
        bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 10'h004;
        bus.cpu_wdata_i = 32'h11223344; bus.cpu_be_i = 4'b0101;
        #2;
        check("wr_mem_we", 32'(bus.mem_we_o), 32'h1);
        check("wr_mem_be", 32'(bus.mem_be_o), 32'h5);
        tick();
        bus.cpu_we_i = 0;
        tick();
        bus.cpu_req_i = 0;
        #2;
        check("wr_readback", bus.cpu_rdata_o, 32'hAA22CC44);
        settle();

        // Wrapping write burst.
        cop_start(1'b1, 10'h3F8, 6'd4);
        #2;
        check("wrap_ack", 32'(bus.cop_ack_o), 32'h1);
        done_cyc = -1;
        addr_q.delete();
        for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
            tick();
            bus.cop_req_i = 0; bus.cop_wdata_i = $urandom;
            #2;
            if (bus.cop_beat_o) addr_q.push_back(32'(bus.mem_addr_o));
            if (bus.cop_done_o) done_cyc = c;
        end
        check("wrap_done_cycle", 32'(done_cyc), 32'd5);
        check("wrap_beats", 32'(addr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("wrap_addr", (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF, 32'(exp_wrap[i]));
        settle();

        // Long read burst with the CPU knocking from cycle 1.
        cop_start(1'b0, 10'h100, 6'd20);
        done_cyc = -1; beats = 0; a10 = -1;
        gnt_q.delete();
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            tick();
            bus.cop_req_i = 0;
            bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 10'h050;
            #2;
            if (bus.cpu_gnt_o) gnt_q.push_back(c);
            if (bus.cop_beat_o) beats++;
            if (c == 10) a10 = int'(bus.mem_addr_o);
            if (bus.cop_done_o) done_cyc = c;
        end
        check("slice_done_cycle", 32'(done_cyc), 32'd23);
        check("slice_beats", 32'(beats), 32'd20);
        check("slice_gnts", 32'(gnt_q.size()), 32'd2);
        check("slice_gnt0", (gnt_q.size() > 0) ? 32'(gnt_q[0]) : 32'hFFFF_FFFF, 32'd9);
        check("slice_gnt1", (gnt_q.size() > 1) ? 32'(gnt_q[1]) : 32'hFFFF_FFFF, 32'd18);
        check("slice_resume_addr", 32'(a10), 32'h120);
        settle();

        // Simultaneous requests straight from reset.
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 10'h020;
        cop_start(1'b1, 10'h040, 6'd2);
        #2;
        check("both_ack0", 32'(bus.cop_ack_o), 32'h1);
        check("both_gnt0", 32'(bus.cpu_gnt_o), 32'h0);
        tick();
        bus.cop_req_i = 0;
        tick();
        tick();
        cop_start(1'b0, 10'h080, 6'd1);
        #2;
        check("both_done3", 32'(bus.cop_done_o), 32'h1);
        check("both_gnt3", 32'(bus.cpu_gnt_o), 32'h0);
        tick();
        #2;
        check("both_gnt4", 32'(bus.cpu_gnt_o), 32'h1);
        check("both_ack4", 32'(bus.cop_ack_o), 32'h0);
        tick();
        bus.cpu_req_i = 0;
        #2;
        check("both_ack5", 32'(bus.cop_ack_o), 32'h1);
        tick();
        bus.cop_req_i = 0;
        tick();
        settle();

        // Zero-length burst.
        cop_start(1'b0, 10'h010, 6'd0);
        #2;
        check("len0_ack", 32'(bus.cop_ack_o), 32'h1);
        tick();
        bus.cop_req_i = 0;
        #2;
        check("len0_done", 32'(bus.cop_done_o), 32'h1);
        check("len0_beat", 32'(bus.cop_beat_o), 32'h0);
        settle();

        // Ready toggling 1,0,1.
        cop_start(1'b1, 10'h0C0, 6'd2);
        tick();
        bus.cop_req_i = 0; bus.cop_ready_i = 1;
        #2;
        check("rdy_beat1", 32'(bus.cop_beat_o), 32'h1);
        tick();
        bus.cop_ready_i = 0;
        #2;
        check("rdy_beat2", 32'(bus.cop_beat_o), 32'h0);
        check("rdy_we2", 32'(bus.mem_we_o), 32'h0);
        tick();
        bus.cop_ready_i = 1;
        #2;
        check("rdy_beat3", 32'(bus.cop_beat_o), 32'h1);
        check("rdy_addr3", 32'(bus.mem_addr_o), 32'h0C4);
        tick();
        #2;
        check("rdy_done4", 32'(bus.cop_done_o), 32'h1);
        settle();

        // Reset in the middle of a read burst.
        cop_start(1'b0, 10'h300, 6'd10);
        tick();
        bus.cop_req_i = 0;
        tick();
        tick();
        #2;
        check("rst_beat3_addr", 32'(bus.mem_addr_o), 32'h308);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        #2;
        check("rst_done", 32'(bus.cop_done_o), 32'h0);
        check("rst_beat", 32'(bus.cop_beat_o), 32'h0);
        check("rst_cop_rvalid", 32'(bus.cop_rvalid_o), 32'h0);
        check("rst_cop_rdata", bus.cop_rdata_o, 32'h0);
        tick();
        cop_start(1'b0, 10'h200, 6'd2);
        tick();
        bus.cop_req_i = 0;
        #2;
        check("rst_new_addr", 32'(bus.mem_addr_o), 32'h200);
        settle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 399) != 0);
            if (!bus.cpu_req_i || m_gnt_last) begin
                bus.cpu_req_i   = ($urandom_range(0, 2) == 0);
                bus.cpu_we_i    = 1'($urandom);
                bus.cpu_addr_i  = AW'($urandom);
                bus.cpu_wdata_i = $urandom;
                bus.cpu_be_i    = TW'($urandom);
            end
            if (bus.cop_req_i && m_ack_last) bus.cop_req_i = 0;
            else if (!bus.cop_req_i && !m_active && !m_slot && !m_done && $urandom_range(0, 5) == 0) begin
                bus.cop_req_i  = 1;
                bus.cop_we_i   = 1'($urandom);
                bus.cop_addr_i = AW'($urandom);
                bus.cop_len_i  = LW'($urandom_range(0, 23));
            end
            bus.cop_ready_i = ($urandom_range(0, 3) != 0);
            bus.cop_wdata_i = $urandom;
        end
        rst_n = 1;
        settle();
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
